// File: rtl/alu_seq.sv
// Clocked ALU: one operation per valid/ready handshake.
// Logic/add/sub finish in one cycle; MUL iterates shift-add.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_order,
   input  logic [WIDTH-1:0] reg_1,
   input  logic [WIDTH-1:0] reg_2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

   localparam logic [2:0] OP_OR   = 3'b000;
   localparam logic [2:0] OP_NAND = 3'b001;
   localparam logic [2:0] OP_NOR  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_ILL  = 3'b111;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t state, state_nx;

   logic                 accept;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mpr;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [CNT_W-1:0]     cnt;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     res;
   logic                 res_c;
   logic                 res_v;
   logic                 res_err;

   assign accept = in_valid & in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nx = (alu_order == OP_MUL) ? MUL : DONE;
         end
         MUL: begin
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Single-cycle result for every opcode except MUL
   always_comb begin
      sum     = {1'b0, reg_1} + {1'b0, reg_2};
      diff    = {1'b0, reg_1} - {1'b0, reg_2};
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_err = 1'b0;
      unique case (alu_order)
         OP_OR:   res = reg_1 | reg_2;
         OP_NAND: res = ~(reg_1 & reg_2);
         OP_NOR:  res = ~(reg_1 | reg_2);
         OP_AND:  res = reg_1 & reg_2;
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (reg_1[WIDTH-1] == reg_2[WIDTH-1]) &&
                    (sum[WIDTH-1] != reg_1[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (reg_1[WIDTH-1] != reg_2[WIDTH-1]) &&
                    (diff[WIDTH-1] != reg_1[WIDTH-1]);
         end
         OP_MUL:  res = '0;
         OP_ILL:  res_err = 1'b1;
         default: res_err = 1'b1;
      endcase
   end

   // One shift-add step: add multiplicand when multiplier LSB is set
   always_comb begin
      acc_nx = acc + (mpr[0] ? mcand : '0);
   end

   // Operand latching, multiply iteration and result/flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out <= '0;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
         err     <= 1'b0;
         mcand   <= '0;
         mpr     <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (alu_order == OP_MUL) begin
                     mcand <= {{WIDTH{1'b0}}, reg_1};
                     mpr   <= reg_2;
                     acc   <= '0;
                     cnt   <= '0;
                  end else begin
                     alu_out <= res;
                     flag_z  <= ~res_err & (res == '0);
                     flag_n  <= res[WIDTH-1];
                     flag_c  <= res_c;
                     flag_v  <= res_v;
                     err     <= res_err;
                  end
               end
            end
            MUL: begin
               acc   <= acc_nx;
               mcand <= mcand << 1;
               mpr   <= mpr >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  alu_out <= acc_nx[WIDTH-1:0];
                  flag_z  <= (acc_nx[WIDTH-1:0] == '0);
                  flag_n  <= acc_nx[WIDTH-1];
                  flag_c  <= |acc_nx[2*WIDTH-1:WIDTH];
                  flag_v  <= 1'b0;
                  err     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
